// File: rtl/color_pkg.sv
// color_pkg
// Shared definitions for the palette lookup: palette geometry, the packed
// RGB type, the scan FSM state type and the palette contents.
// No ports (package).
package color_pkg;

  localparam int PALETTE_SIZE = 20;
  localparam int IDX_W        = 5;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Palette contents. Entry 12 repeats entry 5 on purpose so the
  // lowest-index-wins rule is exercised by real data.
  function automatic rgb_t palette_entry(input int k);
    case (k)
      0:       palette_entry = 24'hFF0000;
      1:       palette_entry = 24'h00FF00;
      2:       palette_entry = 24'h0000FF;
      3:       palette_entry = 24'hFFFF00;
      4:       palette_entry = 24'h00FFFF;
      5:       palette_entry = 24'hFF00FF;
      6:       palette_entry = 24'hC0C0C0;
      7:       palette_entry = 24'h808080;
      8:       palette_entry = 24'h800000;
      9:       palette_entry = 24'h808000;
      10:      palette_entry = 24'h008000;
      11:      palette_entry = 24'h800080;
      12:      palette_entry = 24'hFF00FF;
      13:      palette_entry = 24'h008080;
      14:      palette_entry = 24'h000080;
      15:      palette_entry = 24'hFFA500;
      16:      palette_entry = 24'hA52A2A;
      17:      palette_entry = 24'hFFFFFF;
      18:      palette_entry = 24'h123456;
      19:      palette_entry = 24'h000000;
      default: palette_entry = 24'h000000;
    endcase
  endfunction

endpackage

// File: rtl/color_picker_rom.sv
// color_picker_rom
// Palette ROM with a registered read port (one cycle of read latency).
// Ports:
//   clk  - rising-edge clock
//   addr - palette index to read
//   data - palette entry at the address sampled on the previous edge
module color_picker_rom #(
  parameter int PALETTE_SIZE = color_pkg::PALETTE_SIZE,
  parameter int IDX_W        = color_pkg::IDX_W
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  addr,
  output logic [23:0]       data
);
  import color_pkg::*;

  rgb_t rom [PALETTE_SIZE];

  for (genvar gi = 0; gi < PALETTE_SIZE; gi++) begin : g_rom
    assign rom[gi] = palette_entry(gi);
  end

  always_ff @(posedge clk) begin
    data <= rom[addr];
  end

endmodule

// File: rtl/color_picker.sv
// color_picker
// Looks up a 24-bit RGB value in the palette ROM by linear scan and reports
// whether it was found and at which (lowest) index.
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous, active-low reset
//   pick       - lookup request, accepted only while idle
//   pickColor  - RGB value to find, captured with an accepted pick
//   busy       - high while the scan runs
//   done       - one-cycle pulse when a scan completes
//   found      - result of the last completed scan
//   colorIndex - index of the last successful match
module color_picker #(
  parameter int PALETTE_SIZE = color_pkg::PALETTE_SIZE,
  parameter int IDX_W        = color_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pick,
  input  logic [23:0]       pickColor,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [IDX_W-1:0]  colorIndex
);
  import color_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PALETTE_SIZE - 1);

  state_t           state_reg, state_next;
  rgb_t             color_reg, color_next;
  logic [IDX_W-1:0] addr_reg, addr_next;
  // rd_idx/rd_valid track which entry is currently on the ROM output,
  // since the address counter runs one step ahead and saturates at the end.
  logic [IDX_W-1:0] rd_idx_reg, rd_idx_next;
  logic             rd_valid_reg, rd_valid_next;
  logic             found_reg, found_next;
  logic [IDX_W-1:0] index_reg, index_next;
  rgb_t             rom_data;
  logic             hit, exhausted;

  color_picker_rom #(
    .PALETTE_SIZE (PALETTE_SIZE),
    .IDX_W        (IDX_W)
  ) u_rom (
    .clk  (clk),
    .addr (addr_reg),
    .data (rom_data)
  );

  assign hit       = rd_valid_reg && (rom_data == color_reg);
  assign exhausted = rd_valid_reg && (rd_idx_reg == LAST_IDX);

  always_comb begin
    state_next    = state_reg;
    color_next    = color_reg;
    addr_next     = addr_reg;
    rd_idx_next   = rd_idx_reg;
    rd_valid_next = 1'b0;
    found_next    = found_reg;
    index_next    = index_reg;
    case (state_reg)
      IDLE: begin
        if (pick) begin
          color_next = pickColor;
          addr_next  = '0;
          state_next = SCAN;
        end
      end
      SCAN: begin
        rd_idx_next   = addr_reg;
        rd_valid_next = 1'b1;
        if (addr_reg != LAST_IDX) begin
          addr_next = addr_reg + 1'b1;
        end
        // The first hit stops the scan, so duplicates resolve to the lowest index.
        if (hit) begin
          found_next    = 1'b1;
          index_next    = rd_idx_reg;
          state_next    = DONE;
          rd_valid_next = 1'b0;
        end else if (exhausted) begin
          found_next    = 1'b0;
          state_next    = DONE;
          rd_valid_next = 1'b0;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      color_reg    <= '0;
      addr_reg     <= '0;
      rd_idx_reg   <= '0;
      rd_valid_reg <= 1'b0;
      found_reg    <= 1'b0;
      index_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      color_reg    <= color_next;
      addr_reg     <= addr_next;
      rd_idx_reg   <= rd_idx_next;
      rd_valid_reg <= rd_valid_next;
      found_reg    <= found_next;
      index_reg    <= index_next;
    end
  end

  assign busy       = (state_reg == SCAN);
  assign done       = (state_reg == DONE);
  assign found      = found_reg;
  assign colorIndex = index_reg;

endmodule

// File: tb/tb_color_picker.sv
// tb_color_picker
// Self-checking bench for color_picker: directed scenarios plus randomized
// lookups compared against a simple search over the bench's own palette copy.
module tb_color_picker;

  localparam int N = 20;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         pick = 1'b0;
  logic [23:0]  pickColor = '0;
  logic         busy, done, found;
  logic [W-1:0] colorIndex;

  int checks = 0;
  int failures = 0;

  logic [23:0] pal [N] = '{
    24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00, 24'h00FFFF,
    24'hFF00FF, 24'hC0C0C0, 24'h808080, 24'h800000, 24'h808000,
    24'h008000, 24'h800080, 24'hFF00FF, 24'h008080, 24'h000080,
    24'hFFA500, 24'hA52A2A, 24'hFFFFFF, 24'h123456, 24'h000000
  };

  bit exp_found = 1'b0;
  int exp_index = 0;

  color_picker #(.PALETTE_SIZE(N), .IDX_W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .pick       (pick),
    .pickColor  (pickColor),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .colorIndex (colorIndex)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Lowest index holding the color, or -1 if absent.
  function automatic int ref_lookup(input logic [23:0] c);
    for (int i = 0; i < N; i++) begin
      if (pal[i] == c) return i;
    end
    return -1;
  endfunction

  // Issues one pick from idle and follows it to completion.
  // noise: toggle pick and scramble pickColor while the scan runs.
  task automatic run_scan(input logic [23:0] c, input bit noise);
    int k;
    int want;
    int n;
    bit seen;
    k    = ref_lookup(c);
    want = (k >= 0) ? k + 2 : N + 1;
    n    = 0;
    seen = 1'b0;
    pickColor = c;
    pick = 1'b1;
    @(posedge clk);
    #1;
    pick = 1'b0;
    check_value("busy_after_pick", 32'(busy), 32'd1);
    while (!seen && n < 40) begin
      if (noise) begin
        pick = 1'($urandom_range(0, 1));
        pickColor = 24'($urandom);
      end
      @(posedge clk);
      #1;
      n++;
      if (done) begin
        seen = 1'b1;
      end else begin
        check_value("busy_scan", 32'(busy), 32'd1);
        check_value("found_held", 32'(found), 32'(exp_found));
        check_value("index_held", 32'(colorIndex), 32'(exp_index));
      end
    end
    pick = 1'b0;
    check_value("done_seen", 32'(seen), 32'd1);
    check_value("done_latency", 32'(n), 32'(want));
    check_value("busy_at_done", 32'(busy), 32'd0);
    if (k >= 0) begin
      exp_found = 1'b1;
      exp_index = k;
    end else begin
      exp_found = 1'b0;
    end
    check_value("found", 32'(found), 32'(exp_found));
    check_value("index", 32'(colorIndex), 32'(exp_index));
    $display("scan color=%06h noise=%0b cycles=%0d found=%0b index=%0d exp_found=%0b exp_index=%0d",
             c, noise, n, found, colorIndex, exp_found, exp_index);
    @(posedge clk);
    #1;
    check_value("done_one_cycle", 32'(done), 32'd0);
    check_value("idle_busy", 32'(busy), 32'd0);
  endtask

  // Re-pulse pick at E3 with another color while scanning for pal[10].
  task automatic repulse_scan();
    int n;
    int dones;
    n = 0;
    dones = 0;
    pickColor = pal[10];
    pick = 1'b1;
    @(posedge clk);
    #1;
    pick = 1'b0;
    while (n < 30) begin
      pick = (n == 2) ? 1'b1 : 1'b0;
      pickColor = (n == 2) ? pal[2] : pal[10];
      @(posedge clk);
      #1;
      n++;
      if (done) begin
        dones++;
        check_value("repulse_latency", 32'(n), 32'd12);
      end
    end
    pick = 1'b0;
    exp_found = 1'b1;
    exp_index = 10;
    check_value("repulse_dones", 32'(dones), 32'd1);
    check_value("repulse_found", 32'(found), 32'd1);
    check_value("repulse_index", 32'(colorIndex), 32'd10);
    $display("repulse scan dones=%0d found=%0b index=%0d", dones, found, colorIndex);
  endtask

  // Reset at E5 of a scan for pal[15], then make sure nothing completes.
  task automatic reset_mid_scan();
    int dones;
    dones = 0;
    pickColor = pal[15];
    pick = 1'b1;
    @(posedge clk);
    #1;
    pick = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_value("rst_busy", 32'(busy), 32'd0);
    check_value("rst_done", 32'(done), 32'd0);
    check_value("rst_found", 32'(found), 32'd0);
    check_value("rst_index", 32'(colorIndex), 32'd0);
    reset = 1'b1;
    exp_found = 1'b0;
    exp_index = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check_value("rst_no_done", 32'(dones), 32'd0);
    $display("reset mid-scan busy=%0b found=%0b index=%0d stray_dones=%0d", busy, found, colorIndex, dones);
  endtask

  initial begin
    int sel;
    logic [23:0] c;

    // Reset with a simultaneous pick: the pick must be dropped.
    reset = 1'b0;
    pick = 1'b1;
    pickColor = pal[0];
    repeat (3) @(posedge clk);
    #1;
    check_value("reset_busy", 32'(busy), 32'd0);
    check_value("reset_done", 32'(done), 32'd0);
    check_value("reset_found", 32'(found), 32'd0);
    check_value("reset_index", 32'(colorIndex), 32'd0);
    reset = 1'b1;
    pick = 1'b0;
    @(posedge clk);
    #1;
    check_value("pick_during_reset_dropped", 32'(busy), 32'd0);
    $display("reset busy=%0b done=%0b found=%0b index=%0d", busy, done, found, colorIndex);

    run_scan(pal[0], 1'b0);
    run_scan(pal[19], 1'b0);
    run_scan(pal[7], 1'b0);
    run_scan(24'hABCDEF, 1'b0);
    repulse_scan();
    run_scan(pal[12], 1'b0);
    reset_mid_scan();
    run_scan(pal[15], 1'b0);
    // Back-to-back: the second pick is sampled on the first idle edge.
    run_scan(pal[3], 1'b0);
    run_scan(pal[17], 1'b0);

    for (int t = 0; t < 30; t++) begin
      sel = int'($urandom_range(0, 3));
      if (sel == 0) c = 24'($urandom);
      else c = pal[$urandom_range(0, N - 1)];
      run_scan(c, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/color_picker.md
COLOR_PICKER -- requirements
Module: color_picker

Interface
REQ-001 The block SHALL have parameter PALETTE_SIZE, default 20, the number of palette entries scanned.
REQ-002 The block SHALL have parameter IDX_W, default 5, the index width; it SHALL satisfy 2**IDX_W >= PALETTE_SIZE.
REQ-003 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1; reset is synchronous and active-low, sampled only on clk rising edges.
REQ-005 The block SHALL have port pick, input, 1, a lookup request sampled each edge.
REQ-006 The block SHALL have port pickColor, input, 24, the RGB value (0xRRGGBB) to locate, sampled with pick.
REQ-007 The block SHALL have port busy, output, 1, high while a scan is in progress.
REQ-008 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-009 The block SHALL have port found, output, 1, the result of the last completed scan; valid from done onward.
REQ-010 The block SHALL have port colorIndex, output, IDX_W, the palette index of the last successful match.

Function
REQ-011 States SHALL be IDLE, SCAN and DONE.
REQ-012 In IDLE, pick=1 at edge E0 SHALL latch pickColor, clear the address counter to 0, enter SCAN and raise busy.
REQ-013 In SCAN, the address counter SHALL increment by 1 per cycle from 0 to PALETTE_SIZE-1 and SHALL then hold.
REQ-014 The ROM read SHALL have 1-cycle registered latency, so the entry at index k is compared against the latched color at edge E(k+2).
REQ-015 A match at index k SHALL load colorIndex=k and found=1 at edge E(k+2), move to DONE and stop the scan.
REQ-016 If no entry matches, then at edge E(PALETTE_SIZE+1) the block SHALL set found=0, leave colorIndex unchanged and move to DONE.
REQ-017 If entries are duplicated, the lowest matching index SHALL win.
REQ-018 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE.
REQ-019 pick asserted while in SCAN or DONE SHALL be ignored; it SHALL NOT be queued.
REQ-020 pickColor changes after E0 SHALL NOT affect the scan in progress.
REQ-021 A new pick accepted in IDLE SHALL NOT clear found or colorIndex until that scan's completion edge.
REQ-022 pickColor bits SHALL be compared exactly with no masking; the comparison is 24-bit equality.

Reset
REQ-023 reset=0 at any edge SHALL force IDLE, busy=0, done=0, found=0, colorIndex=0 and address counter=0.
REQ-024 A reset asserted mid-scan SHALL abort the scan without producing a done pulse.
REQ-025 A pick sampled at the same edge as reset=0 SHALL be discarded.

Structure
REQ-026 Package color_pkg SHALL hold PALETTE_SIZE, IDX_W, the rgb_t 24-bit typedef and the state enum; the colorSelect block SHALL share it.
REQ-027 The palette SHALL be the existing colorROM, instantiated as the one sub-module and addressed by the scan counter; it SHALL NOT be duplicated inline.
REQ-028 All state SHALL live in a single clocked process; next-state and compare logic SHALL be combinational.

Verification
REQ-029 Directed: pickColor = ROM[0], pick pulsed at E0 -> busy high E0 to E2, done pulse after E2, found=1, colorIndex=0.
REQ-030 Directed: pickColor = ROM[19] -> done after E21, found=1, colorIndex=19.
REQ-031 Directed: colorIndex=7 from a prior scan, pickColor absent from the palette -> done after E21, found=0, colorIndex stays 7.
REQ-032 Directed: pick re-pulsed at E3 during a scan for ROM[10] with a different color -> only one done, after E12, colorIndex=10.
REQ-033 Directed: reset=0 at E5 of a scan for ROM[15] -> IDLE from E5, no done pulse, found=0, colorIndex=0; a fresh pick then completes normally.
REQ-034 Directed: back-to-back picks (second pick in the cycle after done) -> both scans complete, each with its own correct index.
